// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: ID/EXE pipeline register bundle plus the EXE-side stall/flush controls
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic ex_stall;
  logic flush;
  logic out_valid;
  logic wb_en_o;
  logic mem_r_o;
  logic mem_w_o;
  logic b_o;
  logic s_o;
  logic imm_o;
  logic [3:0] exe_cmd_o;
  logic [DATA_W-1:0] val_rn_o;
  logic [DATA_W-1:0] val_rm_o;
  logic [DATA_W-1:0] pc_o;
  logic [ADDR_W-1:0] dest_o;
  logic [ADDR_W-1:0] src1_o;
  logic [ADDR_W-1:0] src2_o;
  logic [11:0] shift_operand_o;
  logic [23:0] signed_imm_o;
  modport master (
    input ex_stall, flush,
    output out_valid, wb_en_o, mem_r_o, mem_w_o, b_o, s_o, imm_o, exe_cmd_o,
           val_rn_o, val_rm_o, pc_o, dest_o, src1_o, src2_o, shift_operand_o, signed_imm_o
  );
  modport slave (
    output ex_stall, flush,
    input out_valid, wb_en_o, mem_r_o, mem_w_o, b_o, s_o, imm_o, exe_cmd_o,
          val_rn_o, val_rm_o, pc_o, dest_o, src1_o, src2_o, shift_operand_o, signed_imm_o
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-subset decode, register file, RAW hazard detect and ID/EXE register.
// Define ID_WB_BYPASS_EN to make a same-cycle write-back visible to operand reads.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_NUM = 16,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  input logic [31:0] instruction,
  input logic [DATA_W-1:0] pc_in,
  input logic z,
  input logic c,
  input logic n,
  input logic v,
  input logic wb_en,
  input logic [ADDR_W-1:0] wb_dest,
  input logic [DATA_W-1:0] wb_value,
  input logic exe_wb_en,
  input logic mem_wb_en,
  input logic [ADDR_W-1:0] exe_dest,
  input logic [ADDR_W-1:0] mem_dest,
  output logic hazard,
  id_stage_pipe_if.master ex
);
  localparam logic [ADDR_W:0] RN = (ADDR_W+1)'(REG_NUM);
  logic [DATA_W-1:0] rf [REG_NUM];
  logic [1:0] mode;
  logic [3:0] opcode, cmd_dp, cmd;
  logic s_bit, imm, is_str, cond_ok, defined, wb, mem_r, mem_w, br, s, use1, use2, hz1, hz2;
  logic [ADDR_W-1:0] src1, src2, dest;
  logic [DATA_W-1:0] val_rn, val_rm;
  assign mode = instruction[27:26];
  assign opcode = instruction[24:21];
  assign s_bit = instruction[20];
  assign imm = instruction[25];
  assign is_str = mode == 2'b01 && !s_bit;
  assign src1 = ADDR_W'(instruction[19:16]);
  assign dest = ADDR_W'(instruction[15:12]);
  assign src2 = is_str ? dest : ADDR_W'(instruction[3:0]);
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
`ifdef ID_WB_BYPASS_EN
    return ({1'b0, a} >= RN) ? '0 : (wb_en && a == wb_dest) ? wb_value : rf[a];
`else
    return ({1'b0, a} >= RN) ? '0 : rf[a];
`endif
  endfunction
  assign val_rn = rd(src1);
  assign val_rm = rd(src2);
  always_comb begin
    case (instruction[31:28])
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'ha: cond_ok = n == v;
      4'hb: cond_ok = n != v;
      4'hc: cond_ok = !z && n == v;
      4'hd: cond_ok = z || n != v;
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  always_comb begin
    case (opcode)
      4'b1101: cmd_dp = 4'b0001;
      4'b1111: cmd_dp = 4'b1001;
      4'b0100: cmd_dp = 4'b0010;
      4'b0101: cmd_dp = 4'b0011;
      4'b0010: cmd_dp = 4'b0100;
      4'b0110: cmd_dp = 4'b0101;
      4'b0000: cmd_dp = 4'b0110;
      4'b1100: cmd_dp = 4'b0111;
      4'b0001: cmd_dp = 4'b1000;
      4'b1010: cmd_dp = 4'b0100;
      4'b1000: cmd_dp = 4'b0110;
      default: cmd_dp = 4'b0000;
    endcase
  end
  // every defined data-processing opcode maps to a non-zero ALU command
  assign defined = cmd_dp != 4'b0000;
  always_comb begin
    cmd = '0;
    wb = 1'b0;
    mem_r = 1'b0;
    mem_w = 1'b0;
    br = 1'b0;
    s = 1'b0;
    if (cond_ok)
      case (mode)
        2'b00: begin
          cmd = cmd_dp;
          wb = defined && opcode != 4'b1010 && opcode != 4'b1000;
          s = defined && s_bit;
        end
        2'b01: begin
          cmd = 4'b0010;
          mem_r = s_bit;
          mem_w = !s_bit;
          wb = s_bit;
        end
        2'b10: br = 1'b1;
        default: ;
      endcase
  end
  assign use1 = !((mode == 2'b00 && (opcode == 4'b1101 || opcode == 4'b1111)) || mode == 2'b10);
  assign use2 = (!imm && mode == 2'b00) || is_str;
  assign hz1 = use1 && ((exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1));
  assign hz2 = use2 && ((exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2));
  assign hazard = in_valid && (hz1 || hz2);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int i = 0; i < REG_NUM; i++) rf[i] <= DATA_W'(i);
    else if (wb_en && {1'b0, wb_dest} < RN)
      rf[wb_dest] <= wb_value;
  end
  // flush beats stall; a stalled EXE keeps the register frozen even over a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex.out_valid <= 1'b0;
      ex.wb_en_o <= 1'b0;
      ex.mem_r_o <= 1'b0;
      ex.mem_w_o <= 1'b0;
      ex.b_o <= 1'b0;
      ex.s_o <= 1'b0;
      ex.exe_cmd_o <= '0;
      ex.imm_o <= 1'b0;
      ex.val_rn_o <= '0;
      ex.val_rm_o <= '0;
      ex.pc_o <= '0;
      ex.dest_o <= '0;
      ex.src1_o <= '0;
      ex.src2_o <= '0;
      ex.shift_operand_o <= '0;
      ex.signed_imm_o <= '0;
    end else if (ex.flush || (!ex.ex_stall && (hazard || !in_valid))) begin
      ex.out_valid <= 1'b0;
      ex.wb_en_o <= 1'b0;
      ex.mem_r_o <= 1'b0;
      ex.mem_w_o <= 1'b0;
      ex.b_o <= 1'b0;
      ex.s_o <= 1'b0;
      ex.exe_cmd_o <= '0;
    end else if (!ex.ex_stall) begin
      ex.out_valid <= 1'b1;
      ex.wb_en_o <= wb;
      ex.mem_r_o <= mem_r;
      ex.mem_w_o <= mem_w;
      ex.b_o <= br;
      ex.s_o <= s;
      ex.exe_cmd_o <= cmd;
      ex.imm_o <= imm;
      ex.val_rn_o <= val_rn;
      ex.val_rm_o <= val_rm;
      ex.pc_o <= pc_in;
      ex.dest_o <= dest;
      ex.src1_o <= src1;
      ex.src2_o <= src2;
      ex.shift_operand_o <= instruction[11:0];
      ex.signed_imm_o <= instruction[23:0];
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe with a spec-level reference model
module tb_id_stage_pipe;
  typedef struct packed {
    logic v, wb, mr, mw, b, s;
    logic [3:0] cmd;
    logic [31:0] rn, rm;
    logic [3:0] dest, s1, s2;
    logic imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [31:0] pc;
  } out_t;
  logic clk = 0, rst = 0, in_valid = 0, z = 0, c = 0, n = 0, v = 0;
  logic wb_en = 0, exe_wb_en = 0, mem_wb_en = 0, hazard;
  logic [31:0] instruction = 0, pc_in = 0, wb_value = 0;
  logic [3:0] wb_dest = 0, exe_dest = 0, mem_dest = 0;
  id_stage_pipe_if #(.DATA_W(32), .ADDR_W(4)) ex();
  id_stage_pipe #(.DATA_W(32), .REG_NUM(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
    .z(z), .c(c), .n(n), .v(v), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .hazard(hazard), .ex(ex)
  );
  always #5 clk = ~clk;
  out_t q[$];
  out_t cur = '0;
  out_t snap;
  logic [31:0] mrf [16];
  logic [4:0] dp [16];
  int compared = 0, mismatched = 0;
  bit mon_en = 0;
`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_RN = 32'hAA;
`else
  localparam logic [31:0] BYP_RN = 32'h2;
`endif
  task automatic check(input string nm, input logic [159:0] a, input logic [159:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic out_t dut_out();
    out_t o;
    o = '{ex.out_valid, ex.wb_en_o, ex.mem_r_o, ex.mem_w_o, ex.b_o, ex.s_o, ex.exe_cmd_o,
          ex.val_rn_o, ex.val_rm_o, ex.dest_o, ex.src1_o, ex.src2_o, ex.imm_o,
          ex.shift_operand_o, ex.signed_imm_o, ex.pc_o};
    return o;
  endfunction
  function automatic out_t ctl(input out_t o);
    out_t r = '0;
    r.v = o.v; r.wb = o.wb; r.mr = o.mr; r.mw = o.mw; r.b = o.b; r.s = o.s; r.cmd = o.cmd;
    return r;
  endfunction
  function automatic out_t bub(input out_t o);
    out_t r = o;
    r.v = 0; r.wb = 0; r.mr = 0; r.mw = 0; r.b = 0; r.s = 0; r.cmd = 0;
    return r;
  endfunction
  // even codes test a predicate, odd codes its negation; 1111 negates "always"
  function automatic bit cond_pass(input logic [3:0] cd);
    bit [7:0] p;
    p = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
    return cd[0] ? !p[cd[3:1]] : p[cd[3:1]];
  endfunction
  function automatic logic [31:0] rdm(input logic [3:0] r);
`ifdef ID_WB_BYPASS_EN
    if (wb_en && r == wb_dest) return wb_value;
`endif
    return mrf[r];
  endfunction
  function automatic bit hz_pred();
    logic [15:0] busy;
    logic [1:0] md;
    logic [3:0] op, s2;
    bit u1, u2;
    md = instruction[27:26];
    op = instruction[24:21];
    busy = (exe_wb_en ? 16'(1) << exe_dest : 16'h0) | (mem_wb_en ? 16'(1) << mem_dest : 16'h0);
    s2 = (md == 2'b01 && !instruction[20]) ? instruction[15:12] : instruction[3:0];
    u1 = !(md == 2'b10 || (md == 2'b00 && (op == 4'hd || op == 4'hf)));
    u2 = (md == 2'b00 && !instruction[25]) || (md == 2'b01 && !instruction[20]);
    return in_valid && ((u1 && busy[instruction[19:16]]) || (u2 && busy[s2]));
  endfunction
  function automatic out_t predict();
    out_t o = '0;
    logic [1:0] md;
    logic [3:0] op;
    logic sb;
    md = instruction[27:26];
    op = instruction[24:21];
    sb = instruction[20];
    o.v = 1;
    o.imm = instruction[25];
    o.sh = instruction[11:0];
    o.si = instruction[23:0];
    o.pc = pc_in;
    o.dest = instruction[15:12];
    o.s1 = instruction[19:16];
    o.s2 = (md == 2'b01 && !sb) ? instruction[15:12] : instruction[3:0];
    o.rn = rdm(o.s1);
    o.rm = rdm(o.s2);
    if (cond_pass(instruction[31:28])) begin
      if (md == 2'b00 && dp[op][4]) begin
        o.cmd = dp[op][3:0];
        o.wb = !(op == 4'b1010 || op == 4'b1000);
        o.s = sb;
      end else if (md == 2'b01) begin
        o.cmd = 4'b0010; o.mr = sb; o.mw = !sb; o.wb = sb;
      end else if (md == 2'b10) o.b = 1;
    end
    return o;
  endfunction
  task automatic tick();
    bit hz;
    #1;
    hz = hz_pred();
    check("hazard", 160'(hazard), 160'(hz));
    if (ex.flush) cur = bub(cur);
    else if (ex.ex_stall) cur = cur;
    else if (hz || !in_valid) cur = bub(cur);
    else cur = predict();
    q.push_back(cur);
    mon_en = 1;
    @(posedge clk);
    if (wb_en) mrf[wb_dest] = wb_value;
    @(negedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    out_t e, a;
    if (mon_en) begin
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard: output cycle with no expected entry");
      end else begin
        e = q.pop_front();
        a = dut_out();
        check("ctrl", 160'(ctl(a)), 160'(ctl(e)));
        if (e.v) check("data", 160'(a), 160'(e));
      end
    end
  end
  task automatic quiet();
    in_valid = 0; wb_en = 0; exe_wb_en = 0; mem_wb_en = 0; ex.ex_stall = 0; ex.flush = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin mrf[i] = i; dp[i] = 0; end
    dp[4'b1101] = 5'b1_0001; dp[4'b1111] = 5'b1_1001; dp[4'b0100] = 5'b1_0010;
    dp[4'b0101] = 5'b1_0011; dp[4'b0010] = 5'b1_0100; dp[4'b0110] = 5'b1_0101;
    dp[4'b0000] = 5'b1_0110; dp[4'b1100] = 5'b1_0111; dp[4'b0001] = 5'b1_1000;
    dp[4'b1010] = 5'b1_0100; dp[4'b1000] = 5'b1_0110;
    ex.ex_stall = 0; ex.flush = 0;
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", 160'(dut_out()), 160'(0));
    rst = 1;
    @(negedge clk); #2;
    instruction = 32'hE0821003; pc_in = 32'h100; in_valid = 1;
    tick();
    check("add_valid", 160'(ex.out_valid), 160'(1));
    check("add_cmd", 160'(ex.exe_cmd_o), 160'(4'b0010));
    check("add_wb", 160'(ex.wb_en_o), 160'(1));
    check("add_rn", 160'(ex.val_rn_o), 160'(2));
    check("add_rm", 160'(ex.val_rm_o), 160'(3));
    check("add_dest", 160'(ex.dest_o), 160'(1));
    exe_wb_en = 1; exe_dest = 3;
    #1 check("raw_hazard", 160'(hazard), 160'(1));
    tick();
    check("raw_bubble", 160'(ex.out_valid), 160'(0));
    exe_wb_en = 0;
    tick();
    check("raw_clear", 160'(ex.out_valid), 160'(1));
    instruction = 32'h0A000004; z = 0;
    tick();
    check("beq_nt_b", 160'(ex.b_o), 160'(0));
    check("beq_nt_valid", 160'(ex.out_valid), 160'(1));
    z = 1;
    tick();
    check("beq_t_b", 160'(ex.b_o), 160'(1));
    check("beq_t_imm", 160'(ex.signed_imm_o), 160'(24'h000004));
    instruction = 32'hE0821003; z = 0;
    tick();
    snap = dut_out();
    instruction = 32'hE0811002; pc_in = 32'h200; ex.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 160'(dut_out()), 160'(snap));
    end
    ex.flush = 1;
    tick();
    check("flush_over_stall", 160'(ex.out_valid), 160'(0));
    ex.flush = 0; ex.ex_stall = 0;
    instruction = 32'hE0821003; wb_en = 1; wb_dest = 2; wb_value = 32'hAA;
    tick();
    check("wb_same_cycle_rn", 160'(ex.val_rn_o), 160'(BYP_RN));
    wb_en = 0;
    for (int k = 0; k < 2000; k++) begin
      instruction = $urandom();
      if ($urandom_range(1, 0) == 1) instruction[31:28] = 4'he;
      pc_in = $urandom();
      in_valid = $urandom_range(9, 0) != 0;
      {z, c, n, v} = 4'($urandom());
      wb_en = $urandom_range(9, 0) < 4; wb_dest = 4'($urandom()); wb_value = $urandom();
      exe_wb_en = $urandom_range(9, 0) < 3; exe_dest = 4'($urandom());
      mem_wb_en = $urandom_range(9, 0) < 3; mem_dest = 4'($urandom());
      ex.ex_stall = $urandom_range(19, 0) < 3;
      ex.flush = $urandom_range(24, 0) < 2;
      tick();
    end
    quiet();
    mon_en = 0;
    rst = 0;
    #1 check("midrun_reset", 160'(dut_out()), 160'(0));
    cur = '0;
    for (int i = 0; i < 16; i++) mrf[i] = i;
    @(negedge clk); #2;
    rst = 1;
    instruction = 32'hE0851005; in_valid = 1;
    tick();
    check("r5_after_reset", 160'(ex.val_rn_o), 160'(5));
    quiet();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the ARM-subset pipeline: control decode, condition check, register file with write-back port, and a built-in ID/EXE pipeline register.
- Adds RAW hazard detection against the EXE/MEM destinations, plus stall/flush control and a valid bit.
- Sits between the IF/ID register and the EXE stage. All EXE-facing outputs are registered.

Parameters:
- DATA_W, 32, register/data width.
- REG_NUM, 16, number of architectural registers.
- ADDR_W, 4, register index width (2^ADDR_W >= REG_NUM).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  instruction/pc_in are valid
- instruction  in  32  ARM-format instruction
- pc_in  in  DATA_W  PC of instruction
- z,c,n,v  in  1 each  status flags
- wb_en  in  1  write-back enable
- wb_dest  in  ADDR_W  write-back register
- wb_value  in  DATA_W  write-back data
- exe_wb_en, mem_wb_en  in  1 each  downstream write enables
- exe_dest, mem_dest  in  ADDR_W  downstream destinations
- ex_stall  in  1  EXE cannot accept; hold register
- flush  in  1  branch taken; kill instruction in decode
- hazard  out  1  combinational; upstream must stall IF and IF/ID
- out_valid  out  1  registered valid
- wb_en_o, mem_r_o, mem_w_o, b_o, s_o  out  1 each  registered controls
- exe_cmd_o  out  4  registered ALU command
- val_rn_o, val_rm_o  out  DATA_W  registered operands
- dest_o, src1_o, src2_o  out  ADDR_W  registered indices
- imm_o  out  1  registered instruction[25]
- shift_operand_o  out  12  registered instruction[11:0]
- signed_imm_o  out  24  registered instruction[23:0]
- pc_o  out  DATA_W  registered PC

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs are 0; out_valid=0.
  - Register file entry i = i (zero-extended).
- Decode, mode = instr[27:26]:
  - Mode 00 (data processing): opcode -> exe_cmd:
    - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101.
    - AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
    - CMP 1010->0100, wb=0.
    - TST 1000->0110, wb=0.
    - wb=1 for all others; s = instr[20].
    - Undefined opcode: all controls 0.
  - Mode 01, S=1 (LDR): cmd 0010, mem_r=1, wb=1.
  - Mode 01, S=0 (STR): cmd 0010, mem_w=1.
  - Mode 10: b=1.
  - Mode 11: all controls 0.
- Condition instr[31:28]: full 16-code ARM table (EQ..AL; 1111 = never). A failing condition zeroes wb/mem_r/mem_w/b/s/exe_cmd. Data fields are still captured.
- Operand indices:
  - src1 = instr[19:16].
  - src2 = instr[15:12] if STR, else instr[3:0].
- Register file:
  - Reads are asynchronous.
  - Write happens at posedge when wb_en=1.
  - Writes to an index >= REG_NUM are ignored; reads of such an index return 0.
- Source usage:
  - src1 is used unless the instruction is MOV, MVN or branch.
  - src2 is used if (imm=0 and mode 00) or STR.
- hazard = in_valid & ((src1 used & ((exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1))) | (same for src2)).
- Pipeline register priority at each posedge:
  1. flush: bubble (out_valid=0, all controls 0).
  2. ex_stall: hold all outputs.
  3. hazard or !in_valid: bubble.
  4. Otherwise load the decoded values; out_valid=1.
- Latency: one cycle from instruction to registered outputs.
- Simultaneous write and read of the same register without the optional feature: the read returns the old value that cycle.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a read index equal to wb_dest with wb_en=1 returns wb_value combinationally in the same cycle (write-through).
- Undefined: the read returns the stored (old) value; the new value is visible from the next cycle.

Test Plan:
- Reset low mid-run -> all outputs 0 immediately; after release, reading R5 gives 5.
- ADD R1,R2,R3 (0xE0821003), no hazards -> next edge: out_valid=1, exe_cmd_o=0010, wb_en_o=1, val_rn_o=2, val_rm_o=3, dest_o=1.
- Same ADD with exe_wb_en=1, exe_dest=3 -> hazard=1, next edge out_valid=0. Clear exe_wb_en -> loads normally.
- BEQ (0x0A000004) with z=0 -> b_o=0, out_valid=1. Repeat with z=1 -> b_o=1, signed_imm_o=0x000004.
- ex_stall=1 for 3 cycles with a new instruction on the inputs -> outputs unchanged. flush=1 together with ex_stall=1 -> bubble.
- wb_en=1, wb_dest=2, wb_value=0xAA while decoding ADD R1,R2,R3:
  - With ID_WB_BYPASS_EN: val_rn_o=0xAA.
  - Without: val_rn_o=2.
